// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute sequencer for the 8-bit CPU.
// Fetches instruction bytes over a req/ack handshake, reads operands from the
// register file, computes the ALU result and writes it back with flags.
// Instruction format: [7:4] opcode, [3:2] rd, [1:0] rs.
// Optional feature: define SEQ_BRANCH_EN to build the two-byte branches
// JZ (9) and JMP (A); otherwise 9/A are undefined single-byte opcodes.

module instr_sequencer #(
  parameter logic [7:0] RESET_PC      = 8'h00,
  parameter bit         HALT_ON_UNDEF = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] IMemAddr,
  output logic       IMemReq,
  input  logic       IMemAck,
  input  logic [7:0] IMemData,
  output logic [1:0] ReadRegA,
  output logic [1:0] ReadRegB,
  input  logic [7:0] ReadDataA,
  input  logic [7:0] ReadDataB,
  output logic [1:0] WriteReg,
  output logic [7:0] WriteData,
  output logic       WriteEnable,
  output logic       ZeroFlag,
  output logic       CarryFlag,
  output logic       Halted
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;
`ifdef SEQ_BRANCH_EN
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
`endif

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_FETCH_IMM,
    S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] result_q, result_d;
  logic       res_carry_q, res_carry_d;
  logic       zero_q, zero_d;
  logic       carry_q, carry_d;
  logic       run_q, run_d;
  logic [3:0] opcode;
  logic [8:0] alu;
  logic       is_branch;

  assign opcode = ir_q[7:4];

`ifdef SEQ_BRANCH_EN
  assign is_branch = (opcode == OP_JZ) || (opcode == OP_JMP);
`else
  assign is_branch = 1'b0;
`endif

  assign IMemAddr  = pc_q;
  assign ReadRegA  = ir_q[3:2];
  assign ReadRegB  = ir_q[1:0];
  assign ZeroFlag  = zero_q;
  assign CarryFlag = carry_q;

  // 9-bit ALU so ADD carry-out and SUB borrow land in bit 8
  always_comb begin
    alu = 9'h000;
    case (opcode)
      OP_MOV:  alu = {1'b0, ReadDataB};
      OP_ADD:  alu = {1'b0, ReadDataA} + {1'b0, ReadDataB};
      OP_SUB:  alu = {1'b0, ReadDataA} - {1'b0, ReadDataB};
      OP_AND:  alu = {1'b0, ReadDataA & ReadDataB};
      OP_OR:   alu = {1'b0, ReadDataA | ReadDataB};
      OP_XOR:  alu = {1'b0, ReadDataA ^ ReadDataB};
      OP_NOT:  alu = {1'b0, ~ReadDataB};
      default: alu = 9'h000;
    endcase
  end

  // Next-state, datapath updates and state-decoded outputs
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    result_d    = result_q;
    res_carry_d = res_carry_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    run_d       = 1'b1;
    IMemReq     = 1'b0;
    WriteEnable = 1'b0;
    WriteReg    = 2'b00;
    WriteData   = 8'h00;
    Halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        // run_q keeps the request low for the first cycle out of reset
        IMemReq = run_q;
        if (run_q && IMemAck) begin
          ir_d    = IMemData;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP: state_d = S_FETCH;
          OP_HLT: state_d = S_HALT;
          OP_LDI: state_d = S_FETCH_IMM;
          OP_MOV, OP_ADD, OP_SUB, OP_AND,
          OP_OR, OP_XOR, OP_NOT: state_d = S_EXEC;
`ifdef SEQ_BRANCH_EN
          OP_JZ, OP_JMP: state_d = S_FETCH_IMM;
`endif
          default: state_d = HALT_ON_UNDEF ? S_HALT : S_FETCH;
        endcase
      end
      S_FETCH_IMM: begin
        IMemReq = 1'b1;
        if (IMemAck) begin
          result_d    = IMemData;
          res_carry_d = 1'b0;
          pc_d        = pc_q + 8'd1;
          state_d     = is_branch ? S_EXEC : S_WB;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
`ifdef SEQ_BRANCH_EN
          if ((opcode == OP_JMP) || zero_q) begin
            pc_d = result_q;
          end
`endif
        end else begin
          result_d    = alu[7:0];
          res_carry_d = alu[8];
        end
        state_d = S_WB;
      end
      S_WB: begin
        // Branches pass through WB without touching the RF or flags
        if (!is_branch) begin
          WriteEnable = 1'b1;
          WriteReg    = ir_q[3:2];
          WriteData   = result_q;
          zero_d      = (result_q == 8'h00);
          carry_d     = res_carry_q;
        end
        state_d = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State register; async reset discards any pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 8'h00;
      result_q    <= 8'h00;
      res_carry_q <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      result_q    <= result_d;
      res_carry_q <= res_carry_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      run_q       <= run_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed test of instr_sequencer with a byte memory
// model (programmable ack delay) and a 4-entry register file model.
// Branch expectations follow SEQ_BRANCH_EN, matching the DUT build.

module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] IMemAddr, IMemData, ReadDataA, ReadDataB, WriteData;
  logic       IMemReq, IMemAck, WriteEnable, ZeroFlag, CarryFlag, Halted;
  logic [1:0] ReadRegA, ReadRegB, WriteReg;

  logic [7:0] mem [0:255];
  logic [7:0] regs [0:3];
  int         ackDelay = 0;
  int         waitCnt;

  int         checkCount = 0;
  int         errorCount = 0;

  int         cycleCnt, writeCount, ackCount, firstAckCycle, firstWriteCycle;
  logic [7:0] ackLog [0:1023];
  logic [7:0] lastAckAddr;
  logic [1:0] lastWriteReg;
  logic [7:0] lastWriteData;

  instr_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IMemAddr   (IMemAddr),
    .IMemReq    (IMemReq),
    .IMemAck    (IMemAck),
    .IMemData   (IMemData),
    .ReadRegA   (ReadRegA),
    .ReadRegB   (ReadRegB),
    .ReadDataA  (ReadDataA),
    .ReadDataB  (ReadDataB),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .WriteEnable(WriteEnable),
    .ZeroFlag   (ZeroFlag),
    .CarryFlag  (CarryFlag),
    .Halted     (Halted)
  );

  always #5 clk = ~clk;

  // Memory answers combinationally once the request has waited ackDelay cycles
  assign IMemAck   = IMemReq && (waitCnt >= ackDelay);
  assign IMemData  = mem[IMemAddr];
  assign ReadDataA = regs[ReadRegA];
  assign ReadDataB = regs[ReadRegB];

  // Count how long the current request has been waiting for its ack
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) waitCnt <= 0;
    else if (IMemReq && !IMemAck) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  // Register file model: write on the strobe, keep contents across DUT resets
  always @(posedge clk) begin
    if (WriteEnable) regs[WriteReg] <= WriteData;
  end

  // Log accepted fetch addresses and write-back events since the last reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt        <= 0;
      writeCount      <= 0;
      ackCount        <= 0;
      firstAckCycle   <= -1;
      firstWriteCycle <= -1;
      lastAckAddr     <= 8'h00;
      lastWriteReg    <= 2'b00;
      lastWriteData   <= 8'h00;
    end else begin
      cycleCnt <= cycleCnt + 1;
      if (IMemReq && IMemAck) begin
        if (ackCount < 1024) ackLog[ackCount[9:0]] <= IMemAddr;
        ackCount    <= ackCount + 1;
        lastAckAddr <= IMemAddr;
        if (ackCount == 0) firstAckCycle <= cycleCnt;
      end
      if (WriteEnable) begin
        writeCount    <= writeCount + 1;
        lastWriteReg  <= WriteReg;
        lastWriteData <= WriteData;
        if (writeCount == 0) firstWriteCycle <= cycleCnt;
      end
    end
  end

  // Hard stop in case something upstream never terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Address fetched right after the first fetch of addr (9'h100 if none)
  function automatic logic [8:0] findNext(input logic [7:0] addr);
    for (int i = 0; i < 1023; i++) begin
      if (i + 1 >= ackCount) break;
      if (ackLog[i] == addr) return {1'b0, ackLog[i + 1]};
    end
    return 9'h100;
  endfunction

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Reset the DUT with the given ack delay and check the reset-state outputs
  task automatic applyStimulus(input int delay);
    @(negedge clk);
    rst_n    = 1'b0;
    ackDelay = delay;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req", IMemReq, 0);
    checkOutput("rst_we", WriteEnable, 0);
    checkOutput("rst_halted", Halted, 0);
    checkOutput("rst_addr", IMemAddr, 8'h00);
    checkOutput("rst_zero", ZeroFlag, 0);
    checkOutput("rst_carry", CarryFlag, 0);
    rst_n = 1'b1;
  endtask

  task automatic runUntilHalt(input string tag, input int budget);
    int n = 0;
    while (!Halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_halted"}, Halted, 1);
  endtask

  initial begin
    bit found;
    logic prevReq, prevAck;
    logic [7:0] prevAddr;
    int n;

    $display("[TB] starting instr_sequencer test");

    // LDI R0,AA ; HLT
    clearMem();
    mem[0] = 8'h80; mem[1] = 8'hAA; mem[2] = 8'hF0;
    applyStimulus(0);
    checkOutput("t1_req_low_release", IMemReq, 0);
    @(posedge clk); #1;
    checkOutput("t1_req_rise", IMemReq, 1);
    runUntilHalt("t1", 100);
    checkOutput("t1_writes", writeCount, 1);
    checkOutput("t1_wreg", lastWriteReg, 2'd0);
    checkOutput("t1_wdata", lastWriteData, 8'hAA);
    checkOutput("t1_latency", firstWriteCycle - firstAckCycle, 3);
    checkOutput("t1_r0", regs[0], 8'hAA);
    @(negedge clk);
    checkOutput("t1_halt_req", IMemReq, 0);
    checkOutput("t1_halt_we", WriteEnable, 0);

    // R1=F0, R2=20, ADD R1,R2 -> 10 with carry
    clearMem();
    mem[0] = 8'h84; mem[1] = 8'hF0; mem[2] = 8'h88; mem[3] = 8'h20;
    mem[4] = 8'h26; mem[5] = 8'hF0;
    applyStimulus(0);
    runUntilHalt("t2", 100);
    checkOutput("t2_writes", writeCount, 3);
    checkOutput("t2_wreg", lastWriteReg, 2'd1);
    checkOutput("t2_wdata", lastWriteData, 8'h10);
    checkOutput("t2_carry", CarryFlag, 1);
    checkOutput("t2_zero", ZeroFlag, 0);
    checkOutput("t2_r1", regs[1], 8'h10);

    // R1=R2=55, SUB R1,R2 -> 00, zero set, no borrow
    clearMem();
    mem[0] = 8'h84; mem[1] = 8'h55; mem[2] = 8'h88; mem[3] = 8'h55;
    mem[4] = 8'h36; mem[5] = 8'hF0;
    applyStimulus(0);
    runUntilHalt("t3", 100);
    checkOutput("t3_wdata", lastWriteData, 8'h00);
    checkOutput("t3_zero", ZeroFlag, 1);
    checkOutput("t3_carry", CarryFlag, 0);

    // LDI R0,AA ; HLT with every fetch acked after 3 wait cycles
    clearMem();
    mem[0] = 8'h80; mem[1] = 8'hAA; mem[2] = 8'hF0;
    applyStimulus(3);
    prevReq = IMemReq; prevAck = IMemAck; prevAddr = IMemAddr;
    n = 0;
    while (!Halted && n < 200) begin
      @(negedge clk);
      n++;
      if (prevReq && !prevAck) begin
        checkOutput("t4_req_held", IMemReq, 1);
        checkOutput("t4_addr_stable", IMemAddr, prevAddr);
        checkOutput("t4_no_we_wait", WriteEnable, 0);
      end
      prevReq = IMemReq; prevAck = IMemAck; prevAddr = IMemAddr;
    end
    checkOutput("t4_halted", Halted, 1);
    checkOutput("t4_writes", writeCount, 1);
    checkOutput("t4_wdata", lastWriteData, 8'hAA);
    checkOutput("t4_latency", firstWriteCycle - firstAckCycle, 6);

    // PC wrap: LDI R0 at 00 (imm F0), NOPs, LDI R1 at FF takes imm from 00
    clearMem();
    mem[0] = 8'h80; mem[1] = 8'hF0; mem[8'hFF] = 8'h84;
    applyStimulus(0);
    runUntilHalt("t5", 3000);
    checkOutput("t5_wrap_imm", findNext(8'hFF), 9'h000);
    checkOutput("t5_after_wrap", findNext(8'h00), 9'h001);
    checkOutput("t5_r0", regs[0], 8'hF0);
    checkOutput("t5_r1", regs[1], 8'h80);
    checkOutput("t5_wreg", lastWriteReg, 2'd1);
    checkOutput("t5_pc", IMemAddr, 8'h02);

    // JZ 40 at PC 10 with Z=1
    clearMem();
    mem[0] = 8'h80; mem[1] = 8'h00;
    mem[8'h10] = 8'h90; mem[8'h11] = 8'h40; mem[8'h12] = 8'hF0;
    mem[8'h40] = 8'hF0;
    applyStimulus(0);
    runUntilHalt("t6z1", 200);
`ifdef SEQ_BRANCH_EN
    checkOutput("t6z1_target", findNext(8'h11), 9'h040);
    checkOutput("t6z1_writes", writeCount, 1);
    checkOutput("t6z1_zero", ZeroFlag, 1);
`else
    checkOutput("t6z1_undef", findNext(8'h10), 9'h011);
`endif

    // JZ 40 at PC 10 with Z=0
    mem[1] = 8'h01;
    applyStimulus(0);
    runUntilHalt("t6z0", 200);
`ifdef SEQ_BRANCH_EN
    checkOutput("t6z0_fallthru", findNext(8'h11), 9'h012);
    checkOutput("t6z0_writes", writeCount, 1);
    checkOutput("t6z0_zero", ZeroFlag, 0);
`else
    checkOutput("t6z0_undef", findNext(8'h10), 9'h011);
`endif

    // JMP 05 at PC 00
    clearMem();
    mem[0] = 8'hA0; mem[1] = 8'h05; mem[5] = 8'hF0;
    applyStimulus(0);
    runUntilHalt("t6jmp", 200);
`ifdef SEQ_BRANCH_EN
    checkOutput("t6jmp_target", findNext(8'h01), 9'h005);
`else
    checkOutput("t6jmp_undef", findNext(8'h00), 9'h001);
`endif
    checkOutput("t6jmp_writes", writeCount, 0);

    // Reset asserted during EXEC of ADD R1,R2
    clearMem();
    mem[0] = 8'h84; mem[1] = 8'hF0; mem[2] = 8'h88; mem[3] = 8'h20;
    mem[4] = 8'h26; mem[5] = 8'hF0;
    applyStimulus(0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (lastAckAddr == 8'h04) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("t7_add_fetched", found, 1);
    @(posedge clk); #1;
    checkOutput("t7_writes_before", writeCount, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("t7_we_drop", WriteEnable, 0);
    checkOutput("t7_req_drop", IMemReq, 0);
    checkOutput("t7_pc_reset", IMemAddr, 8'h00);
    @(negedge clk);
    checkOutput("t7_we_hold1", WriteEnable, 0);
    @(negedge clk);
    checkOutput("t7_we_hold2", WriteEnable, 0);
    checkOutput("t7_r1_kept", regs[1], 8'hF0);
    rst_n = 1'b1;
    n = 0;
    while (ackCount == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t7_restart_addr", {ackCount > 0, ackLog[0]}, 9'h100);
    runUntilHalt("t7", 100);
    checkOutput("t7_wdata", lastWriteData, 8'h10);
    checkOutput("t7_carry", CarryFlag, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
